// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the memory/writeback end of the pipeline.
// Imported by the data memory and by the MEM/WB stage top.
package mem_wb_stage_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int REG_IDX_W   = 4;
    localparam int BASE_ADDR   = 1024;
    localparam int MEM_WORDS   = 64;

    // Word alignment test on the low address bits.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read,
// window check against BASE_ADDR, reads of unmapped addresses return zero.
module data_memory
    import mem_wb_stage_pkg::word_aligned;
#(
    parameter int WORD_LENGTH = mem_wb_stage_pkg::WORD_LENGTH,
    parameter int MEM_WORDS   = mem_wb_stage_pkg::MEM_WORDS,
    parameter int BASE_ADDR   = mem_wb_stage_pkg::BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [WORD_LENGTH-1:0] addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic [WORD_LENGTH-1:0] rdata,
    output logic                   in_range
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [WORD_LENGTH-1:0] BASE_W  = WORD_LENGTH'(BASE_ADDR);
    localparam logic [WORD_LENGTH-3:0] DEPTH_W = (WORD_LENGTH-2)'(MEM_WORDS);

    logic [WORD_LENGTH-1:0] offset_s;
    logic [IDX_W-1:0]       idx_s;
    logic                   hit_s;
    logic [WORD_LENGTH-1:0] mem_r [MEM_WORDS];

    // Address decode; BASE_ADDR is word aligned, so offset alignment equals address alignment.
    always_comb begin
        offset_s = addr - BASE_W;
        idx_s    = offset_s[IDX_W+1:2];
        hit_s    = (addr >= BASE_W) && (offset_s[WORD_LENGTH-1:2] < DEPTH_W)
                   && word_aligned(offset_s[1:0]);
    end

    // Asynchronous read with zero returned on a miss.
    always_comb begin
        if (hit_s) begin
            rdata = mem_r[idx_s];
        end else begin
            rdata = {WORD_LENGTH{1'b0}};
        end
        in_range = hit_s;
    end

    // Array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en && hit_s) begin
            mem_r[idx_s] <= wdata;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data memory access, MEM/WB register and
// register-file write interface, plus registered dest/enable for hazard detection.
module mem_wb_stage #(
    parameter int WORD_LENGTH = mem_wb_stage_pkg::WORD_LENGTH,
    parameter int MEM_WORDS   = mem_wb_stage_pkg::MEM_WORDS,
    parameter int BASE_ADDR   = mem_wb_stage_pkg::BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic [WORD_LENGTH-1:0] ALU_result,
    input  logic [WORD_LENGTH-1:0] ST_val,
    input  logic [3:0]             Dest_in,
    input  logic                   WB_EN_in,
    input  logic                   MEM_R_EN_in,
    input  logic                   MEM_W_EN_in,
    output logic [3:0]             WB_Dest,
    output logic [WORD_LENGTH-1:0] WB_Value,
    output logic                   WB_WB_EN,
    output logic [3:0]             MEM_Dest,
    output logic                   MEM_WB_EN,
    output logic                   addr_err
);

    import mem_wb_stage_pkg::REG_IDX_W;

    logic                   store_s;
    logic                   access_s;
    logic                   in_range_s;
    logic [WORD_LENGTH-1:0] rdata_s;

    logic [WORD_LENGTH-1:0] value_r;
    logic [REG_IDX_W-1:0]   dest_r;
    logic                   wb_en_r;
    logic                   addr_err_r;

    // Store and access qualifiers; frozen or resetting cycles touch nothing.
    always_comb begin
        store_s  = MEM_W_EN_in & ~freeze & ~rst;
        access_s = (MEM_R_EN_in | MEM_W_EN_in) & ~freeze;
    end

    data_memory #(
        .WORD_LENGTH (WORD_LENGTH),
        .MEM_WORDS   (MEM_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_data_memory (
        .clk      (clk),
        .wr_en    (store_s),
        .addr     (ALU_result),
        .wdata    (ST_val),
        .rdata    (rdata_s),
        .in_range (in_range_s)
    );

    // MEM/WB register; the writeback select is folded in ahead of the flop.
    // A simultaneous load+store samples the pre-store read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {WORD_LENGTH{1'b0}};
            dest_r  <= {REG_IDX_W{1'b0}};
            wb_en_r <= 1'b0;
        end else if (!freeze) begin
            value_r <= MEM_R_EN_in ? rdata_s : ALU_result;
            dest_r  <= Dest_in;
            wb_en_r <= WB_EN_in;
        end else begin
            value_r <= value_r;
            dest_r  <= dest_r;
            wb_en_r <= wb_en_r;
        end
    end

    // Sticky out-of-range access flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_r <= 1'b0;
        end else if (access_s && !in_range_s) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    assign WB_Value  = value_r;
    assign WB_Dest   = dest_r;
    assign WB_WB_EN  = wb_en_r;
    assign MEM_Dest  = dest_r;
    assign MEM_WB_EN = wb_en_r;
    assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios then random traffic,
// compared against an array-based behavioural model of memory and writeback.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic [31:0] ALU_result, ST_val;
    logic [3:0]  Dest_in;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [3:0]  WB_Dest, MEM_Dest;
    logic [31:0] WB_Value;
    logic        WB_WB_EN, MEM_WB_EN, addr_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [64];
    logic [31:0] exp_value;
    logic [3:0]  exp_dest;
    logic        exp_wb_en;
    logic        exp_err;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .ALU_result(ALU_result), .ST_val(ST_val), .Dest_in(Dest_in),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .WB_Dest(WB_Dest), .WB_Value(WB_Value), .WB_WB_EN(WB_WB_EN),
        .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .addr_err(addr_err)
    );

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'd1024) && (a <= 32'd1276) && ((a % 32'd4) == 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, update the model, check 1 unit after posedge.
    task automatic cyc(input logic r_st, input logic fz, input logic [31:0] alu,
                       input logic [31:0] st, input logic [3:0] d,
                       input logic wb, input logic rd, input logic wr);
        int idx;
        @(negedge clk);
        rst = r_st; freeze = fz; ALU_result = alu; ST_val = st; Dest_in = d;
        WB_EN_in = wb; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
        idx = int'((alu - 32'd1024) / 32'd4);
        if (r_st) begin
            exp_value = 32'd0; exp_dest = 4'd0; exp_wb_en = 1'b0; exp_err = 1'b0;
        end else if (!fz) begin
            if (rd) exp_value = in_rng(alu) ? mdl_mem[idx] : 32'd0;
            else    exp_value = alu;
            exp_dest  = d;
            exp_wb_en = wb;
            if ((rd || wr) && !in_rng(alu)) exp_err = 1'b1;
            if (wr && in_rng(alu)) mdl_mem[idx] = st;
        end
        @(posedge clk);
        #1;
        chk("wb_value",  WB_Value, exp_value);
        chk("wb_dest",   {28'd0, WB_Dest}, {28'd0, exp_dest});
        chk("wb_wb_en",  {31'd0, WB_WB_EN}, {31'd0, exp_wb_en});
        chk("mem_dest",  {28'd0, MEM_Dest}, {28'd0, exp_dest});
        chk("mem_wb_en", {31'd0, MEM_WB_EN}, {31'd0, exp_wb_en});
        chk("addr_err",  {31'd0, addr_err}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] r_alu;
        int sel;
        rst = 1'b1; freeze = 1'b0; ALU_result = 32'd0; ST_val = 32'd0; Dest_in = 4'd0;
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        exp_value = 32'd0; exp_dest = 4'd0; exp_wb_en = 1'b0; exp_err = 1'b0;

        // Reset held two cycles with a writeback pending, then release.
        cyc(1'b1, 1'b0, 32'h55, 32'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h55, 32'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        chk("rst_value", WB_Value, 32'd0);
        cyc(1'b0, 1'b0, 32'h12, 32'd0, 4'd9, 1'b1, 1'b0, 1'b0);
        chk("post_rst_value", WB_Value, 32'h12);

        // Zero-fill memory so every later load has a defined model value.
        for (int i = 0; i < 64; i++)
            cyc(1'b0, 1'b0, 32'd1024 + 32'(4 * i), 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);

        // ALU writeback.
        cyc(1'b0, 1'b0, 32'h0000_00AB, 32'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        chk("alu_value", WB_Value, 32'hAB);
        chk("alu_dest", {28'd0, WB_Dest}, 32'd5);

        // Store then load on consecutive cycles.
        cyc(1'b0, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1028, 32'd0, 4'd3, 1'b1, 1'b1, 1'b0);
        chk("ld_1028", WB_Value, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 32'd1032, 32'd0, 4'd4, 1'b1, 1'b1, 1'b0);
        chk("ld_1032", WB_Value, 32'd0);

        // Freeze holds the load result; a frozen store does not write.
        cyc(1'b0, 1'b0, 32'd1028, 32'd0, 4'd3, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'd7, 32'd0, 4'd8, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'd7, 32'd0, 4'd8, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'd1028, 32'hCAFE0000, 4'd8, 1'b1, 1'b0, 1'b1);
        chk("frz_hold", WB_Value, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 32'd1028, 32'd0, 4'd3, 1'b1, 1'b1, 1'b0);
        chk("frz_nowrite", WB_Value, 32'hDEADBEEF);

        // Frozen store completes on the first unfrozen cycle.
        cyc(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1036, 32'h0BADF00D, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1036, 32'd0, 4'd6, 1'b1, 1'b1, 1'b0);
        chk("held_store", WB_Value, 32'h0BADF00D);

        // Simultaneous load+store returns pre-store data.
        cyc(1'b0, 1'b0, 32'd1040, 32'h11112222, 4'd2, 1'b1, 1'b1, 1'b1);
        chk("ldst_old", WB_Value, 32'd0);
        cyc(1'b0, 1'b0, 32'd1040, 32'd0, 4'd2, 1'b1, 1'b1, 1'b0);
        chk("ldst_new", WB_Value, 32'h11112222);

        // Reset during a store suppresses the write.
        cyc(1'b1, 1'b0, 32'd1044, 32'h12345678, 4'd1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1044, 32'd0, 4'd1, 1'b1, 1'b1, 1'b0);
        chk("rst_store", WB_Value, 32'd0);

        // Boundary words 0 and 63.
        cyc(1'b0, 1'b0, 32'd1024, 32'hA5A5_0000, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1276, 32'h0000_5A5A, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1024, 32'd0, 4'd10, 1'b1, 1'b1, 1'b0);
        chk("bnd_lo", WB_Value, 32'hA5A5_0000);
        cyc(1'b0, 1'b0, 32'd1276, 32'd0, 4'd11, 1'b1, 1'b1, 1'b0);
        chk("bnd_hi", WB_Value, 32'h0000_5A5A);
        chk("bnd_err", {31'd0, addr_err}, 32'd0);

        // Out-of-range accesses set the sticky flag.
        cyc(1'b0, 1'b0, 32'd1020, 32'hFFFF0001, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("oor_err", {31'd0, addr_err}, 32'd1);
        cyc(1'b0, 1'b0, 32'd1280, 32'hFFFF0002, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1026, 32'hFFFF0003, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'd1020, 32'd0, 4'd7, 1'b1, 1'b1, 1'b0);
        chk("oor_load", WB_Value, 32'd0);
        cyc(1'b0, 1'b0, 32'd1024, 32'd0, 4'd7, 1'b1, 1'b1, 1'b0);
        chk("oor_nowrite", WB_Value, 32'hA5A5_0000);
        chk("err_sticky", {31'd0, addr_err}, 32'd1);
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("err_clear", {31'd0, addr_err}, 32'd0);

        // Random traffic, mostly inside the mapped window.
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       r_alu = 32'd1024 + 32'(4 * $urandom_range(0, 63));
            else if (sel == 7) r_alu = 32'($urandom_range(1000, 1300));
            else               r_alu = $urandom;
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), r_alu,
                $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
